// File: rtl/apb_ctrl_pkg.sv
// Shared types and constants for the APB GPIO master/arbiter.
package apb_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    // GPIO block register offsets
    localparam logic [3:0] GPIO_MODER = 4'h0;
    localparam logic [3:0] GPIO_IDR   = 4'h4;
    localparam logic [3:0] GPIO_ODR   = 4'h8;

    // Next round-robin start position after idx, wrapping at n
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant from a request vector; the rotating
// pointer moves to (winner + 1) only when the caller strobes adv_i.
module rr_arbiter
    import apb_ctrl_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req_i,
    input  logic            adv_i,
    output logic [NREQ-1:0] gnt_o
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] win_idx;
    logic [PW-1:0] scan_idx;
    logic          found;
    int            j;

    // Scan requesters starting at the pointer; first one found wins
    always_comb begin
        gnt_o    = '0;
        found    = 1'b0;
        win_idx  = '0;
        scan_idx = '0;
        j        = 0;
        for (int i = 0; i < NREQ; i++) begin
            j = int'(ptr_q) + i;
            if (j >= NREQ) j = j - NREQ;
            scan_idx = PW'(j);
            if (!found && req_i[scan_idx]) begin
                found          = 1'b1;
                gnt_o[scan_idx] = 1'b1;
                win_idx        = scan_idx;
            end
        end
        ptr_d = ptr_q;
        if (adv_i && found) ptr_d = PW'(rr_next(int'(win_idx), NREQ));
    end

    // Pointer register; requester 0 has priority out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/apb_gpio_arbiter.sv
// APB master sharing one GPIO slave between NREQ requesters. Round-robin
// grant in IDLE, SETUP/ACCESS sequencing, per-owner completion pulse and a
// timeout that completes with an error if the slave never asserts PREADY.
module apb_gpio_arbiter
    import apb_ctrl_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int AW      = 4,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic               PCLK,
    input  logic               PRESETn,
    input  logic [NREQ-1:0]    req_i,
    input  logic [NREQ*AW-1:0] addr_i,
    input  logic [NREQ-1:0]    write_i,
    input  logic [NREQ*DW-1:0] wdata_i,
    output logic [NREQ-1:0]    gnt_o,
    output logic [NREQ-1:0]    done_o,
    output logic [DW-1:0]      rdata_o,
    output logic               err_o,
    output logic [AW-1:0]      PADDR,
    output logic [DW-1:0]      PWDATA,
    output logic               PWRITE,
    output logic               PSEL,
    output logic               PENABLE,
    input  logic [DW-1:0]      PRDATA,
    input  logic               PREADY
);

    localparam int CW = $clog2(TIMEOUT + 1);

    apb_state_t      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] owner_q, owner_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            err_q, err_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [AW-1:0]   paddr_q, paddr_d;
    logic [DW-1:0]   pwdata_q, pwdata_d;
    logic            pwrite_q, pwrite_d;
    logic [NREQ-1:0] arb_gnt;
    logic            adv;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk   (PCLK),
        .rst_n (PRESETn),
        .req_i (req_i),
        .adv_i (adv),
        .gnt_o (arb_gnt)
    );

    // Next-state, request capture, timeout counting and completion
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        owner_d  = owner_q;
        done_d   = '0;
        err_d    = err_q;
        rdata_d  = rdata_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        pwrite_d = pwrite_q;
        adv      = 1'b0;
        case (state_q)
            IDLE: begin
                // The completion cycle is itself IDLE; granting there would
                // overlap gnt_o with done_o, so wait one more cycle.
                if (!(|done_q) && (|req_i)) begin
                    adv     = 1'b1;
                    owner_d = arb_gnt;
                    for (int i = 0; i < NREQ; i++) begin
                        if (arb_gnt[i]) begin
                            paddr_d  = addr_i[i*AW +: AW];
                            pwdata_d = wdata_i[i*DW +: DW];
                            pwrite_d = write_i[i];
                        end
                    end
                    state_d = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (PREADY) begin
                    done_d  = owner_q;
                    err_d   = 1'b0;
                    if (!pwrite_q) rdata_d = PRDATA;
                    state_d = IDLE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    done_d  = owner_q;
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and APB/result registers; reset aborts any transfer in flight
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            owner_q  <= '0;
            done_q   <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pwrite_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            owner_q  <= owner_d;
            done_q   <= done_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            pwrite_q <= pwrite_d;
        end
    end

    assign gnt_o   = adv ? arb_gnt : '0;
    assign done_o  = done_q;
    assign err_o   = err_q;
    assign rdata_o = rdata_q;
    assign PADDR   = paddr_q;
    assign PWDATA  = pwdata_q;
    assign PWRITE  = pwrite_q;
    assign PSEL    = (state_q == SETUP) || (state_q == ACCESS);
    assign PENABLE = (state_q == ACCESS);

endmodule
